// File: rtl/store_narrower.sv
// Store-path narrower: lane-aligns register data for byte/halfword/word stores,
// builds byte enables and error/truncation flags, and queues results in a small FIFO.
module store_narrower #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [31:0]      in_addr,
    input  logic [1:0]       in_size,
    input  logic             in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_wdata,
    output logic [3:0]       out_be,
    output logic             out_trunc,
    output logic             out_error,
    output logic [CNT_W-1:0] err_count
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    size_e       size_sel;
    logic        misaligned;
    logic        rsvd_size;
    logic        trunc_next;
    logic        error_next;
    logic [31:0] wdata_next;
    logic [3:0]  be_raw;
    logic [3:0]  be_next;

    assign size_sel = size_e'(in_size);

    // Classification of the request; truncation is only meaningful for narrow sizes.
    always_comb begin
        misaligned = 1'b0;
        rsvd_size  = 1'b0;
        trunc_next = 1'b0;
        case (size_sel)
            SZ_BYTE: begin
                trunc_next = in_sign ? (in_data[31:8] != {24{in_data[7]}})
                                     : (in_data[31:8] != 24'd0);
            end
            SZ_HALF: begin
                misaligned = in_addr[0];
                trunc_next = in_sign ? (in_data[31:16] != {16{in_data[15]}})
                                     : (in_data[31:16] != 16'd0);
            end
            SZ_WORD: begin
                misaligned = (in_addr[1:0] != 2'b00);
            end
            default: begin
                rsvd_size = 1'b1;
            end
        endcase
    end

    assign error_next = misaligned | rsvd_size;

    // Per-lane data replication and enable decode.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_byte;
            logic       lane_hit;

            assign lane_byte = (size_sel == SZ_BYTE) ? in_data[7:0] :
                               (size_sel == SZ_HALF) ? in_data[8*(gi%2) +: 8] :
                                                       in_data[8*gi +: 8];

            assign lane_hit  = (size_sel == SZ_BYTE) ? (in_addr[1:0] == 2'(gi)) :
                               (size_sel == SZ_HALF) ? (in_addr[1] == 1'(gi/2)) :
                               (size_sel == SZ_WORD);

            assign wdata_next[8*gi +: 8] = lane_byte;
            assign be_raw[gi]            = lane_hit;
        end
    endgenerate

    // An erroneous entry must never write memory.
    assign be_next = error_next ? 4'b0000 : be_raw;

    logic [29:0] addr_mem  [DEPTH];
    logic [31:0] wdata_mem [DEPTH];
    logic [3:0]  be_mem    [DEPTH];
    logic        trunc_mem [DEPTH];
    logic        error_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [OCC_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] err_count_reg, err_count_next;
    logic             push;
    logic             pop;

    assign in_ready  = (count_reg < OCC_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        err_count_next = err_count_reg;
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        if (push && error_next && (err_count_reg != {CNT_W{1'b1}})) begin
            err_count_next = err_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            err_count_reg <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            err_count_reg <= err_count_next;
        end
    end

    // Entry storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg]  <= in_addr[31:2];
            wdata_mem[wr_ptr_reg] <= wdata_next;
            be_mem[wr_ptr_reg]    <= be_next;
            trunc_mem[wr_ptr_reg] <= trunc_next;
            error_mem[wr_ptr_reg] <= error_next;
        end
    end

    // Outputs read as zero while empty so stale entries are never presented.
    assign out_addr  = out_valid ? {addr_mem[rd_ptr_reg], 2'b00} : 32'd0;
    assign out_wdata = out_valid ? wdata_mem[rd_ptr_reg] : 32'd0;
    assign out_be    = out_valid ? be_mem[rd_ptr_reg] : 4'd0;
    assign out_trunc = out_valid & trunc_mem[rd_ptr_reg];
    assign out_error = out_valid & error_mem[rd_ptr_reg];
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_store_narrower.sv
// Self-checking bench for store_narrower: randomized and directed store requests
// compared against an arithmetic reference model with a queue-based FIFO.
module tb_store_narrower;

    localparam int DEPTH   = 2;
    localparam int CNT_W   = 8;
    localparam int SAT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        trunc;
        logic        error;
    } ent_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [31:0]      in_addr;
    logic [1:0]       in_size;
    logic             in_sign;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_addr;
    logic [31:0]      out_wdata;
    logic [3:0]       out_be;
    logic             out_trunc;
    logic             out_error;
    logic [CNT_W-1:0] err_count;

    int   total;
    int   bad;
    ent_t q[$];
    int   err_model;

    store_narrower #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr), .in_size(in_size), .in_sign(in_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_wdata(out_wdata), .out_be(out_be),
        .out_trunc(out_trunc), .out_error(out_error), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference narrowing computed from value ranges and address arithmetic.
    function automatic ent_t model_narrow(input logic [31:0] d, input logic [31:0] a,
                                          input logic [1:0] sz, input logic sg);
        ent_t e;
        int   sd;
        sd      = $signed(d);
        e.addr  = a - (a % 32'd4);
        e.trunc = 1'b0;
        e.error = 1'b0;
        case (sz)
            2'd0: begin
                e.wdata = (d % 32'd256) * 32'h0101_0101;
                e.be    = 4'(32'd1 << (a % 32'd4));
                e.trunc = sg ? (sd < -128 || sd > 127) : (d > 32'd255);
            end
            2'd1: begin
                e.wdata = (d % 32'd65536) * 32'h0001_0001;
                e.be    = ((a % 32'd4) >= 32'd2) ? 4'b1100 : 4'b0011;
                e.error = (a % 32'd2) != 32'd0;
                e.trunc = sg ? (sd < -32768 || sd > 32767) : (d > 32'd65535);
            end
            2'd2: begin
                e.wdata = d;
                e.be    = 4'b1111;
                e.error = (a % 32'd4) != 32'd0;
            end
            default: begin
                e.wdata = d;
                e.be    = 4'b0000;
                e.error = 1'b1;
            end
        endcase
        if (e.error) e.be = 4'b0000;
        return e;
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 255));
            1:       return 32'($signed(8'($urandom)));
            2:       return 32'($urandom_range(0, 65535));
            default: return $urandom;
        endcase
    endfunction

    // One clock of stimulus: returns DUT observations and the model's view, then advances the model.
    task automatic drive_cycle(input logic v, input logic [31:0] d, input logic [31:0] a,
                               input logic [1:0] sz, input logic sg, input logic rdy,
                               output logic o_rdy, output logic o_vld, output ent_t o_head,
                               output logic m_rdy, output logic m_vld, output ent_t m_head);
        ent_t e;
        in_valid  = v;
        in_data   = d;
        in_addr   = a;
        in_size   = sz;
        in_sign   = sg;
        out_ready = rdy;
        #1;
        o_rdy  = in_ready;
        o_vld  = out_valid;
        o_head = {out_addr, out_wdata, out_be, out_trunc, out_error};
        m_rdy  = q.size() < DEPTH;
        m_vld  = q.size() > 0;
        m_head = m_vld ? q[0] : '0;
        @(posedge clk);
        if (m_vld && rdy) void'(q.pop_front());
        if (v && m_rdy) begin
            e = model_narrow(d, a, sz, sg);
            q.push_back(e);
            if (e.error && err_model < SAT_MAX) err_model++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_addr = '0; in_size = '0; in_sign = 1'b0;
        q.delete(); err_model = 0;
        #3;
        total++;
        if (out_valid !== 1'b0 || err_count !== '0 || out_addr !== 32'd0 || out_wdata !== 32'd0 ||
            out_be !== 4'd0 || out_trunc !== 1'b0 || out_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got vld=%b cnt=%0d addr=%h wd=%h be=%b tr=%b er=%b, want all zero",
                     out_valid, err_count, out_addr, out_wdata, out_be, out_trunc, out_error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] dv [8] = '{32'h0000_00A5, 32'hFFFF_FF80, 32'h0000_0180, 32'hFFFF_8000,
                                32'h1234_5678, 32'h0000_BEEF, 32'hCAFE_F00D, 32'h0};
        logic [31:0] av [8] = '{32'h1003, 32'h0, 32'h0, 32'h0, 32'h2, 32'h5, 32'h8, 32'h0};
        logic [1:0]  sv [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd3, 2'd0};
        logic        gv [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic orr, ov, mr, mv;
        ent_t oh, mh;
        ent_t first_exp;
        first_exp = {32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive_cycle(i < 7, dv[i], av[i], sv[i], gv[i], 1'b1, orr, ov, oh, mr, mv, mh);
            total++;
            if (orr !== mr || ov !== mv || (mv && oh !== mh)) begin
                bad++;
                $display("FAIL directed_%0d: got rdy=%b vld=%b head=%h want rdy=%b vld=%b head=%h",
                         i, orr, ov, oh, mr, mv, mh);
            end
            if (i == 1) begin
                total++;
                if (oh !== first_exp) begin
                    bad++;
                    $display("FAIL directed_byte_a5: got %h want %h", oh, first_exp);
                end
            end
            total++;
            if (err_count !== CNT_W'(err_model)) begin
                bad++;
                $display("FAIL directed_err_count_%0d: got %0d want %0d", i, err_count, err_model);
            end
        end
    endtask

    task automatic test_random();
        logic orr, ov, mr, mv;
        ent_t oh, mh;
        for (int i = 0; i < 200; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, rand_data(), $urandom, 2'($urandom_range(0, 3)),
                        1'($urandom), $urandom_range(0, 2) != 0, orr, ov, oh, mr, mv, mh);
            total++;
            if (orr !== mr || ov !== mv || (mv && oh !== mh) || err_count !== CNT_W'(err_model)) begin
                bad++;
                $display("FAIL random_%0d: got rdy=%b vld=%b head=%h cnt=%0d want rdy=%b vld=%b head=%h cnt=%0d",
                         i, orr, ov, oh, err_count, mr, mv, mh, err_model);
            end
        end
    endtask

    task automatic test_drain();
        logic orr, ov, mr, mv;
        ent_t oh, mh;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            drive_cycle(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, orr, ov, oh, mr, mv, mh);
            total++;
            if (ov !== mv || (mv && oh !== mh)) begin
                bad++;
                $display("FAIL drain_%0d: got vld=%b head=%h want vld=%b head=%h", i, ov, oh, mv, mh);
            end
        end
        total++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_timeout: got out_valid=%b model_entries=%0d want empty", out_valid, q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic orr, ov, mr, mv;
        ent_t oh, mh, held;
        test_drain();
        held = '0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            drive_cycle(1'b1, rand_data(), $urandom, 2'($urandom_range(0, 2)), 1'($urandom), 1'b0,
                        orr, ov, oh, mr, mv, mh);
            total++;
            if (orr !== mr || ov !== mv || (mv && oh !== mh)) begin
                bad++;
                $display("FAIL stall_%0d: got rdy=%b vld=%b head=%h want rdy=%b vld=%b head=%h",
                         i, orr, ov, oh, mr, mv, mh);
            end
            if (i == 1) held = oh;
            if (i > 1) begin
                total++;
                if (oh !== held) begin
                    bad++;
                    $display("FAIL stall_hold_%0d: got %h want %h", i, oh, held);
                end
            end
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_in_ready: got %b want 0", in_ready);
        end
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1'b1, rand_data(), $urandom, 2'($urandom_range(0, 3)), 1'($urandom), 1'b1,
                        orr, ov, oh, mr, mv, mh);
            total++;
            if (orr !== mr || ov !== mv || (mv && oh !== mh)) begin
                bad++;
                $display("FAIL stream_%0d: got rdy=%b vld=%b head=%h want rdy=%b vld=%b head=%h",
                         i, orr, ov, oh, mr, mv, mh);
            end
        end
        test_drain();
    endtask

    task automatic test_saturation();
        logic orr, ov, mr, mv;
        ent_t oh, mh;
        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'b1, $urandom, $urandom, 2'd3, 1'($urandom), 1'b1, orr, ov, oh, mr, mv, mh);
            if (mv) begin
                total++;
                if (oh !== mh) begin
                    bad++;
                    $display("FAIL sat_entry_%0d: got %h want %h", i, oh, mh);
                end
            end
        end
        total++;
        if (err_count !== CNT_W'(SAT_MAX) || err_model != SAT_MAX) begin
            bad++;
            $display("FAIL err_saturate: got %0d want %0d", err_count, SAT_MAX);
        end
        test_drain();
    endtask

    task automatic test_reset_mid();
        logic orr, ov, mr, mv;
        ent_t oh, mh, exp_first;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, rand_data(), $urandom, 2'($urandom_range(0, 3)), 1'($urandom), 1'b0,
                        orr, ov, oh, mr, mv, mh);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || err_count !== '0 || out_wdata !== 32'd0 || out_be !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid: got vld=%b cnt=%0d wd=%h be=%b want 0 0 0 0",
                     out_valid, err_count, out_wdata, out_be);
        end
        q.delete();
        err_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_first = model_narrow(32'h0000_7F3C, 32'h0000_2002, 2'd1, 1'b1);
        drive_cycle(1'b1, 32'h0000_7F3C, 32'h0000_2002, 2'd1, 1'b1, 1'b0, orr, ov, oh, mr, mv, mh);
        drive_cycle(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, orr, ov, oh, mr, mv, mh);
        total++;
        if (ov !== 1'b1 || oh !== exp_first) begin
            bad++;
            $display("FAIL reset_mid_first: got vld=%b head=%h want vld=1 head=%h", ov, oh, exp_first);
        end
        test_drain();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
